mem_request_sequencer: RTL

Sits between the CPU bus and the SRAM memory controller and owns all bus sequencing. It accepts one 16-bit CPU request at a time and splits the address space:
- 0x0000–0xBFFF is routed to the memory controller, with read/write enables held for the fixed number of cycles the byte-serial controller needs.
- 0xC000–0xFFFF is routed to a ready-handshaked I/O port.

It returns read data with a single-cycle acknowledge and guarantees the idle cycle the controller needs between accesses to reset its byte phase.

---
 rtl/mem_request_sequencer_pkg.sv | 30 +++
 rtl/mem_request_sequencer_down_counter.sv | 29 ++
 rtl/mem_request_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_request_sequencer_pkg.sv
// Shared types and defaults for the CPU-to-SRAM/I-O request sequencer.
// Holds the sequencer state encoding, address split and cycle-count defaults.
package mem_request_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MEM_RD  = 3'd1,
        MEM_WR  = 3'd2,
        IO_WAIT = 3'd3,
        ACK     = 3'd4
    } seq_state_t;

    localparam logic [15:0] DEF_IO_BASE      = 16'hC000;
    localparam int          DEF_READ_CYCLES  = 3;
    localparam int          DEF_WRITE_CYCLES = 2;
    localparam int          DEF_IO_TIMEOUT   = 255;

    // Read data returned when an I/O access is abandoned by the timeout.
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

    // Counter width large enough for the longest of the three loads.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_request_sequencer_down_counter.sv
// Loadable down-counter with a terminal flag raised while the count equals 1.
// Used by the sequencer for memory enable length and the optional I/O timeout.
module seq_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_inv,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;

    // Saturates at zero so an unbounded I/O wait cannot wrap back to 1.
    always_ff @(posedge clk) begin
        if (!reset_inv) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign terminal = (count_reg == WIDTH'(1));

endmodule

// File: rtl/mem_request_sequencer.sv
// CPU bus sequencer: routes one request at a time to the byte-serial SRAM
// controller or a ready-handshaked I/O port. Optional SEQ_IO_TIMEOUT_EN bounds I/O waits.
module mem_request_sequencer
    import mem_request_sequencer_pkg::*;
#(
    parameter int          READ_CYCLES  = DEF_READ_CYCLES,
    parameter int          WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter logic [15:0] IO_BASE      = DEF_IO_BASE,
    parameter int          IO_TIMEOUT   = DEF_IO_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_inv,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic [15:0] mc_address,
    output logic [15:0] mc_data_in,
    input  logic [15:0] mc_data_out,
    output logic        mc_read_en,
    output logic        mc_write_en,
    output logic [15:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    output logic        io_read,
    output logic        io_write,
    input  logic        io_ready
);

    localparam int CNT_W = cnt_width(READ_CYCLES, WRITE_CYCLES, IO_TIMEOUT);

    seq_state_t state_reg;
    seq_state_t state_next;

    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        we_reg;
    logic [15:0] rdata_reg;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             cnt_terminal;

    seq_down_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .reset_inv  (reset_inv),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .terminal   (cnt_terminal)
    );

    always_ff @(posedge clk) begin
        if (!reset_inv) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    cnt_load = 1'b1;
                    if (cpu_addr >= IO_BASE) begin
                        state_next     = IO_WAIT;
                        cnt_load_value = CNT_W'(IO_TIMEOUT);
                    end else if (cpu_we) begin
                        state_next     = MEM_WR;
                        cnt_load_value = CNT_W'(WRITE_CYCLES);
                    end else begin
                        state_next     = MEM_RD;
                        cnt_load_value = CNT_W'(READ_CYCLES);
                    end
                end
            end
            MEM_RD, MEM_WR: begin
                if (cnt_terminal) begin
                    state_next = ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IO_WAIT: begin
                cnt_dec = 1'b1;
                if (io_ready) begin
                    state_next = ACK;
                end
`ifdef SEQ_IO_TIMEOUT_EN
                else if (cnt_terminal) begin
                    state_next = ACK;
                end
`endif
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured only on acceptance, so CPU bus activity
    // during an access cannot disturb the controller or I/O port.
    always_ff @(posedge clk) begin
        if (!reset_inv) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && cpu_req) begin
                addr_reg  <= cpu_addr;
                wdata_reg <= cpu_wdata;
                we_reg    <= cpu_we;
            end
            if ((state_reg == MEM_RD) && cnt_terminal) begin
                rdata_reg <= mc_data_out;
            end
            if ((state_reg == IO_WAIT) && !we_reg) begin
                if (io_ready) begin
                    rdata_reg <= io_rdata;
                end
`ifdef SEQ_IO_TIMEOUT_EN
                else if (cnt_terminal) begin
                    rdata_reg <= TIMEOUT_RDATA;
                end
`endif
            end
        end
    end

    // Strobes decode from the state register only; ACK drives them all low,
    // which is the controller's byte-phase recovery cycle.
    always_comb begin
        mc_read_en  = 1'b0;
        mc_write_en = 1'b0;
        io_read     = 1'b0;
        io_write    = 1'b0;
        cpu_ack     = 1'b0;
        case (state_reg)
            MEM_RD:  mc_read_en  = 1'b1;
            MEM_WR:  mc_write_en = 1'b1;
            IO_WAIT: begin
                io_read  = ~we_reg;
                io_write = we_reg;
            end
            ACK:     cpu_ack     = 1'b1;
            default: begin
            end
        endcase
    end

    assign mc_address = addr_reg;
    assign mc_data_in = wdata_reg;
    assign io_addr    = addr_reg;
    assign io_wdata   = wdata_reg;
    assign cpu_rdata  = rdata_reg;

endmodule
